// File: rtl/vga_scan_timer.sv
// 640x480@60 VGA raster timer: sync/enable decode, ping-pong VRAM band select,
// frame tick and blink flag. Define VGA_SCAN_REG_OUT_EN to register the decoded outputs.
module vga_scan_timer #(
   parameter int unsigned H_VIS        = 640,
   parameter int unsigned H_FP         = 16,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_BP         = 48,
   parameter int unsigned V_VIS        = 480,
   parameter int unsigned V_FP         = 10,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_BP         = 33,
   parameter int unsigned BAND_LINES   = 32,
   parameter int unsigned BLINK_FRAMES = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_ce,
   output logic       hsync,
   output logic       vsync,
   output logic       display_en,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       band_sel,
   output logic       line_start,
   output logic       frame_tick,
   output logic       blink
);

   localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
   localparam logic [9:0] V_VIS_C    = 10'(V_VIS);
   localparam logic [9:0] HS_BEG     = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG     = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [9:0] BAND_MASK  = 10'(BAND_LINES - 1);
   localparam logic [6:0] FR_LAST    = 7'(BLINK_FRAMES - 1);
   localparam logic [6:0] BLINK_HALF = 7'(BLINK_FRAMES / 2);

   logic [9:0] hpos_q, hpos_d;
   logic [9:0] vpos_q, vpos_d;
   logic       band_q, band_d;
   logic [6:0] frame_cnt_q, frame_cnt_d;
   logic       line_flag_q, line_flag_d;
   logic       frame_flag_q, frame_flag_d;

   logic       hsync_s, vsync_s, de_s;
   logic       line_start_s, frame_tick_s;

   assign line_start_s = line_flag_q & pix_ce;
   assign frame_tick_s = frame_flag_q & pix_ce;

   // Next-state: raster counters, band select, pulse flags and frame counter
   always_comb begin
      hpos_d       = hpos_q;
      vpos_d       = vpos_q;
      band_d       = band_q;
      line_flag_d  = line_flag_q;
      frame_flag_d = frame_flag_q;
      frame_cnt_d  = frame_cnt_q;
      if (pix_ce) begin
         if (hpos_q == H_LAST) begin
            hpos_d = 10'd0;
            if (vpos_q == V_LAST) begin
               vpos_d = 10'd0;
               band_d = 1'b0;
            end else begin
               vpos_d = vpos_q + 10'd1;
               // Flip banks when leaving the last line of a visible band
               if ((vpos_q < V_VIS_C) && (((vpos_q + 10'd1) & BAND_MASK) == 10'd0)) begin
                  band_d = ~band_q;
               end else begin
                  band_d = band_q;
               end
            end
         end else begin
            hpos_d = hpos_q + 10'd1;
         end
         line_flag_d  = (hpos_d == 10'd0);
         frame_flag_d = (hpos_d == 10'd0) && (vpos_d == V_VIS_C);
      end else begin
         line_flag_d  = line_flag_q;
         frame_flag_d = frame_flag_q;
      end
      if (frame_tick_s) begin
         frame_cnt_d = (frame_cnt_q == FR_LAST) ? 7'd0 : (frame_cnt_q + 7'd1);
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hpos_q       <= 10'd0;
         vpos_q       <= 10'd0;
         band_q       <= 1'b0;
         line_flag_q  <= 1'b0;
         frame_flag_q <= 1'b0;
         frame_cnt_q  <= 7'd0;
      end else begin
         hpos_q       <= hpos_d;
         vpos_q       <= vpos_d;
         band_q       <= band_d;
         line_flag_q  <= line_flag_d;
         frame_flag_q <= frame_flag_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   // Decode of the current counters
   always_comb begin
      hsync_s = ~((hpos_q >= HS_BEG) && (hpos_q <= HS_END));
      vsync_s = ~((vpos_q >= VS_BEG) && (vpos_q <= VS_END));
      de_s    = (hpos_q < H_VIS_C) && (vpos_q < V_VIS_C);
   end

`ifdef VGA_SCAN_REG_OUT_EN
   logic hsync_q, vsync_q, de_q, band_out_q;

   // One pix_ce of delay to line up with the VRAM read latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         de_q       <= 1'b0;
         band_out_q <= 1'b0;
      end else if (pix_ce) begin
         hsync_q    <= hsync_s;
         vsync_q    <= vsync_s;
         de_q       <= de_s;
         band_out_q <= band_q;
      end else begin
         hsync_q    <= hsync_q;
         vsync_q    <= vsync_q;
         de_q       <= de_q;
         band_out_q <= band_out_q;
      end
   end

   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign display_en = de_q;
   assign band_sel   = band_out_q;
`else
   assign hsync      = hsync_s;
   assign vsync      = vsync_s;
   // Counters sit at 0,0 during reset, which would otherwise decode as visible
   assign display_en = de_s & ~reset;
   assign band_sel   = band_q;
`endif

   assign hpos       = hpos_q;
   assign vpos       = vpos_q;
   assign line_start = line_start_s;
   assign frame_tick = frame_tick_s;
   assign blink      = (frame_cnt_q < BLINK_HALF);

endmodule

// File: tb/tb_vga_scan_timer.sv
// Scoreboard bench for vga_scan_timer: a full-size instance for line/band timing and a
// shrunken instance so whole frames, blink wrap and pix_ce toggling fit in a short run.
module tb_vga_scan_timer;

   logic clk = 1'b0;
   logic reset;
   logic pix_ce;

   always #5 clk = ~clk;

   logic       b_hs, b_vs, b_de, b_band, b_ls, b_ft, b_bl;
   logic [9:0] b_h, b_v;
   logic       s_hs, s_vs, s_de, s_band, s_ls, s_ft, s_bl;
   logic [9:0] s_h, s_v;

   vga_scan_timer u_big (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .hsync(b_hs), .vsync(b_vs), .display_en(b_de), .hpos(b_h), .vpos(b_v),
      .band_sel(b_band), .line_start(b_ls), .frame_tick(b_ft), .blink(b_bl)
   );

   vga_scan_timer #(
      .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .BAND_LINES(2), .BLINK_FRAMES(6)
   ) u_small (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .hsync(s_hs), .vsync(s_vs), .display_en(s_de), .hpos(s_h), .vpos(s_v),
      .band_sel(s_band), .line_start(s_ls), .frame_tick(s_ft), .blink(s_bl)
   );

   typedef struct {
      int hvis, hfp, hs, hbp, vvis, vfp, vs, vbp, band, bf;
   } cfg_t;

   typedef struct {
      string       tag;
      int          dut;
      int          n;
      logic [26:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   cfg_t big_c;
   cfg_t small_c;
   int   n;
   int   tk_b, tk_s;
   logic ft_b, ft_s;

   localparam logic [26:0] RESET_VEC = {4'b1100, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0};

   // {hsync, vsync, display_en, band_sel} for the raster position after n advances
   function automatic logic [3:0] dec(cfg_t c, int cnt);
      int ht, vt, h, v, vb;
      logic [3:0] r;
      ht = c.hvis + c.hfp + c.hs + c.hbp;
      vt = c.vvis + c.vfp + c.vs + c.vbp;
      h  = cnt % ht;
      v  = (cnt / ht) % vt;
      vb = (v < c.vvis) ? v : c.vvis;
      r[3] = !((h >= c.hvis + c.hfp) && (h < c.hvis + c.hfp + c.hs));
      r[2] = !((v >= c.vvis + c.vfp) && (v < c.vvis + c.vfp + c.vs));
      r[1] = (h < c.hvis) && (v < c.vvis);
      r[0] = ((vb / c.band) % 2) == 1;
      return r;
   endfunction

   function automatic logic [26:0] expect_v(cfg_t c, int cnt, logic ce, int ticks);
      int ht, vt, h, v;
      logic [3:0] d;
      logic ls, ft, bl;
      ht = c.hvis + c.hfp + c.hs + c.hbp;
      vt = c.vvis + c.vfp + c.vs + c.vbp;
      h  = cnt % ht;
      v  = (cnt / ht) % vt;
`ifdef VGA_SCAN_REG_OUT_EN
      d = (cnt == 0) ? 4'b1100 : dec(c, cnt - 1);
`else
      d = dec(c, cnt);
`endif
      ls = ce && (cnt > 0) && (h == 0);
      ft = ce && (h == 0) && (v == c.vvis);
      bl = (ticks % c.bf) < (c.bf / 2);
      return {d, ls, ft, bl, 10'(h), 10'(v)};
   endfunction

   task automatic push(string tag, int dut, logic [26:0] e);
      exp_t x;
      x.tag = tag; x.dut = dut; x.n = n; x.exp = e;
      sb_q.push_back(x);
   endtask

   task automatic push_model(string tag);
      logic [26:0] eb, es;
      eb = expect_v(big_c, n, pix_ce, tk_b);
      es = expect_v(small_c, n, pix_ce, tk_s);
      ft_b = eb[21];
      ft_s = es[21];
      push(tag, 0, eb);
      push(tag, 1, es);
   endtask

   // One clock: account for the advance just taken, drive the new enable, queue expectations
   task automatic step(logic ce_new, string tag);
      @(posedge clk);
      #1;
      if (!reset && pix_ce) begin
         n = n + 1;
         if (ft_b) tk_b = tk_b + 1;
         if (ft_s) tk_s = tk_s + 1;
      end
      pix_ce = ce_new;
      push_model(tag);
   endtask

   task automatic clear_model();
      n = 0; tk_b = 0; tk_s = 0; ft_b = 1'b0; ft_s = 1'b0;
   endtask

   task automatic hold_reset(string tag, int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         reset = 1'b1;
         clear_model();
         push(tag, 0, RESET_VEC);
         push(tag, 1, RESET_VEC);
      end
   endtask

   // Direct check of both instances against the reset state while reset is held
   task automatic check_reset_state(string tag);
      logic [26:0] act_b, act_s;
      #1;
      act_b = {b_hs, b_vs, b_de, b_band, b_ls, b_ft, b_bl, b_h, b_v};
      act_s = {s_hs, s_vs, s_de, s_band, s_ls, s_ft, s_bl, s_h, s_v};
      checks = checks + 1;
      if ((act_b !== RESET_VEC) || (act_s !== RESET_VEC)) begin
         failures = failures + 1;
         $display("FAIL %s reset state big=%b small=%b exp=%b", tag, act_b, act_s, RESET_VEC);
      end
   endtask

   task automatic release_reset(string tag);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      pix_ce = 1'b1;
      clear_model();
      push_model(tag);
   endtask

   // Monitor: compare every queued expectation against the DUT at the falling edge
   always @(negedge clk) begin
      exp_t e;
      logic [26:0] act;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.dut == 0)
            act = {b_hs, b_vs, b_de, b_band, b_ls, b_ft, b_bl, b_h, b_v};
         else
            act = {s_hs, s_vs, s_de, s_band, s_ls, s_ft, s_bl, s_h, s_v};
         checks = checks + 1;
         if (act !== e.exp) begin
            failures = failures + 1;
            $display("FAIL %s dut%0d n=%0d got{hs,vs,de,band,ls,ft,bl,h,v}=%b_%0d_%0d exp=%b_%0d_%0d",
                     e.tag, e.dut, e.n, act[26:20], act[19:10], act[9:0],
                     e.exp[26:20], e.exp[19:10], e.exp[9:0]);
         end
      end
   end

   // Watchdog: the stimulus must complete before the time limit expires
   initial begin
      #(2000000);
      failures = failures + 1;
      $display("FAIL timeout: stimulus did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      big_c   = '{640, 16, 96, 48, 480, 10, 2, 33, 32, 120};
      small_c = '{8, 2, 3, 3, 8, 1, 2, 1, 2, 6};
      reset   = 1'b1;
      pix_ce  = 1'b1;
      clear_model();

      hold_reset("reset", 3);
      check_reset_state("reset_direct");
      release_reset("first_cycle");
      // 34 full-size lines: hsync window, line length, band flip at 31->32;
      // ~140 small frames: vsync, frame_tick, band pattern, blink wrap
      for (int i = 0; i < 27200; i++) step(1'b1, "run");
      for (int i = 0; i < 2000; i++) step((i % 2) == 1, "ce_toggle");

      // Asynchronous reset in the middle of a cycle
      @(posedge clk);
      #1;
      if (!reset && pix_ce) n = n + 1;
      #1;
      reset = 1'b1;
      clear_model();
      push("async_rst", 0, RESET_VEC);
      push("async_rst", 1, RESET_VEC);
      hold_reset("rst_hold", 2);
      check_reset_state("rst_hold_direct");
      release_reset("restart");
      for (int i = 0; i < 1000; i++) step(1'b1, "after_restart");

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_scan_timer.md
Name: vga_scan_timer

Overview:
- Generates 640x480@60 VGA raster timing: sync pulses, pixel/line positions, display enable.
- Generates the 32-line band select that steers the ping-pong VRAM pair: one bank is read for display while the other is written.
- Upstream of the VRAM read/write address logic and the game renderer; consumers derive read/write addresses from hpos/vpos.
- Also produces a one-cycle frame tick and a 2 s blink flag, replacing the combinational frame "clock" used by score blinking.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- BAND_LINES, 32, lines per VRAM band; power of two
- BLINK_FRAMES, 120, blink period in frames; flag high for first half

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_ce  in  1  pixel clock enable; counters advance only when 1 (tie high when clk is the 25.175 MHz pixel clock)
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- display_en  out  1  high inside the 640x480 visible area
- hpos  out  10  current pixel column, 0..799
- vpos  out  10  current line, 0..524
- band_sel  out  1  VRAM bank currently read for display
- line_start  out  1  one-cycle pulse at hpos==0 (qualified by pix_ce)
- frame_tick  out  1  one-cycle pulse at vpos==V_VIS, hpos==0 (qualified by pix_ce)
- blink  out  1  high while frame_cnt < BLINK_FRAMES/2

Behaviour:
- Reset is asynchronous, active-high (fixed). While asserted: hpos=0, vpos=0, band_sel=0, frame_cnt=0, hsync=1, vsync=1, display_en=0, line_start=0, frame_tick=0, blink=1.
- H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800. V_TOT = V_VIS+V_FP+V_SYNC+V_BP = 525.
- On each clk edge with pix_ce=1:
  - hpos increments; at H_TOT-1 it wraps to 0 and vpos increments.
  - vpos wraps V_TOT-1 -> 0 when hpos wraps.
- With pix_ce=0, all state holds and the pulse outputs are 0.
- Decoding (current counters, no added latency):
  - hsync=0 for hpos in [656,751]; vsync=0 for vpos in [490,491].
  - display_en = (hpos<640) && (vpos<480).
- band_sel:
  - Toggles on the hpos wrap out of any line where vpos<V_VIS and (vpos+1)%BAND_LINES==0, i.e. at line boundaries 31->32, 63->64, ..., 479->480.
  - Forced to 0 on the vpos wrap 524->0.
  - So each visible band reads alternating banks: band 0 reads bank 0, band 1 reads bank 1, and so on.
- frame_tick and line_start are registered pulses, asserted in the cycle in which the counters hold the target value.
- frame_cnt (7 bit) increments on frame_tick and wraps BLINK_FRAMES-1 -> 0. blink = frame_cnt < BLINK_FRAMES/2.
- Width rule: counters are 10 bit; all comparisons are unsigned; no counter exceeds its TOT-1.
- Reset mid-frame: immediate return to the reset state; the first line after release starts at hpos=0, vpos=0.

Optional Feature:
- Macro: VGA_SCAN_REG_OUT_EN.
- Defined: hsync, vsync, display_en and band_sel are delayed one pix_ce cycle through output registers, aligning them with the 1-cycle VRAM read latency; hpos/vpos are not delayed. The registers reset to 1, 1, 0, 0 respectively.
- Undefined: these outputs are combinational from the counters (0 latency).

Test Plan:
- Release reset with pix_ce=1 -> hpos=0, vpos=0, display_en=1 on the first cycle; hsync first falls at hpos=656 and rises at 752; line length is exactly 800 cycles.
- Run one full frame -> 420000 cycles; vsync low exactly for vpos 490..491 (1600 cycles); frame_tick pulses once, at vpos=480, hpos=0.
- Band check -> band_sel=0 for vpos 0..31, 1 for 32..63, 0 for 64..95, ..., toggle at 479->480; band_sel=0 again at vpos=0 of the next frame.
- pix_ce toggling 1,0,1,0 -> counters advance every other cycle; no pulse is emitted while pix_ce=0; frame period doubles to 840000 cycles.
- 120 frames -> blink high for frames 0..59 and low for 60..119, then high again; frame_cnt wraps 119 -> 0.
- Assert reset at hpos=300, vpos=200 -> outputs go to their reset values asynchronously within the same cycle; on release the count restarts from 0,0.
- With VGA_SCAN_REG_OUT_EN -> hsync falls when hpos=657 and display_en falls when hpos=641; hpos/vpos unchanged relative to the non-registered build.
